// File: rtl/operand_entry_if.sv
// Operand entry bus: button/selection controls in, registered operands and
// valid/ready change notification out.
interface operand_entry_if;
    logic [7:0]  btn;
    logic [1:0]  sel;
    logic        dec;
    logic        clear;
    logic        op_ready;
    logic [63:0] num1;
    logic [31:0] num2;
    logic        op_valid;
    logic        rpt_active;

    modport master (
        output btn, sel, dec, clear, op_ready,
        input  num1, num2, op_valid, rpt_active
    );

    modport slave (
        input  btn, sel, dec, clear, op_ready,
        output num1, num2, op_valid, rpt_active
    );
endinterface

// File: rtl/operand_entry.sv
// Turns debounced digit buttons into registered operands with hold-to-repeat,
// clear, and a valid/ready notification towards the compute stage.
//
// state  | meaning
// IDLE   | no button held since the last release or clear
// HOLD   | button pressed, waiting REPEAT_DELAY before the first repeat
// REPEAT | auto-repeating every REPEAT_RATE cycles
module operand_entry #(
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 10000000
) (
    input logic            clk,
    input logic            rst_n,
    operand_entry_if.slave bus
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       btn_s1_q, btn_s1_d;
    logic [7:0]       btn_s2_q, btn_s2_d;
    logic [7:0]       btn_hist_q, btn_hist_d;
    logic [7:0]       btn_edge_q, btn_edge_d;
    logic [63:0]      num1_q, num1_d;
    logic [31:0]      num2_q, num2_d;
    logic             op_valid_q, op_valid_d;
    logic             rpt_active_q, rpt_active_d;

    logic [7:0]       step_mask;
    logic [3:0]       step_val;
    logic [31:0]      field_cur;
    logic [31:0]      field_new;
    logic             wr;

    always_comb begin
        btn_s1_d   = bus.btn;
        btn_s2_d   = btn_s1_q;
        btn_hist_d = btn_s2_q;
        btn_edge_d = btn_s2_q & ~btn_hist_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        step_mask = '0;

        // btn_hist_q is the synced level aligned with btn_edge_q
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|btn_edge_q) begin
                        step_mask = btn_edge_q;
                        cnt_d     = DELAY_LOAD;
                        state_d   = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (btn_hist_q == 8'h00) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (|btn_edge_q) begin
                        step_mask = btn_edge_q;
                        cnt_d     = DELAY_LOAD;
                        state_d   = HOLD;
                    end else if (cnt_q == '0) begin
                        step_mask = btn_hist_q;
                        cnt_d     = RATE_LOAD;
                        state_d   = REPEAT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        step_val = bus.dec ? 4'hF : 4'h1;
        case (bus.sel)
            2'b00:   field_cur = num1_q[31:0];
            2'b10:   field_cur = num1_q[63:32];
            2'b01:   field_cur = num2_q;
            default: field_cur = '0;
        endcase

        // Each nibble wraps on its own; no carry between nibbles
        field_new = field_cur;
        for (int i = 0; i < 8; i++) begin
            if (step_mask[i]) begin
                field_new[4*i +: 4] = field_cur[4*i +: 4] + step_val;
            end
        end

        num1_d = num1_q;
        num2_d = num2_q;
        wr     = 1'b0;
        if (bus.clear) begin
            num1_d = '0;
            num2_d = '0;
            wr     = 1'b1;
        end else if ((|step_mask) && (bus.sel != 2'b11)) begin
            wr = 1'b1;
            case (bus.sel)
                2'b00:   num1_d[31:0]  = field_new;
                2'b10:   num1_d[63:32] = field_new;
                default: num2_d        = field_new;
            endcase
        end

        if (wr) begin
            op_valid_d = 1'b1;
        end else if (bus.op_ready) begin
            op_valid_d = 1'b0;
        end else begin
            op_valid_d = op_valid_q;
        end

        rpt_active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_hist_q   <= '0;
            btn_edge_q   <= '0;
            num1_q       <= '0;
            num2_q       <= '0;
            op_valid_q   <= 1'b0;
            rpt_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_hist_q   <= btn_hist_d;
            btn_edge_q   <= btn_edge_d;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            op_valid_q   <= op_valid_d;
            rpt_active_q <= rpt_active_d;
        end
    end

    assign bus.num1       = num1_q;
    assign bus.num2       = num2_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.rpt_active = rpt_active_q;

endmodule
